// File: rtl/tt_wrap_pkg.sv
// Shared types and defaults for the multi-core Tiny Tapeout pad wrapper.
package tt_wrap_pkg;

    localparam int DEF_NUM_CORES     = 2;
    localparam int DEF_SEL_W         = 2;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_SETTLE,
        ST_RUN,
        ST_HALT,
        ST_SELFTEST
    } state_t;

    // Low bit of core k's byte lane in the packed core buses.
    function automatic int slice_lo(input int k);
        return 8 * k;
    endfunction

endpackage

// File: rtl/tt_core_select_wrapper_sync.sv
// Width/depth parametrised flop synchroniser with asynchronous clear to zero.
module tt_sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/tt_core_select_wrapper.sv
// Multi-core pad wrapper: syncs reset/inputs, latches a core select after reset and muxes
// the selected core onto registered pads. TT_WRAP_SELFTEST_EN adds a counter self-test mode.
module tt_core_select_wrapper
    import tt_wrap_pkg::*;
#(
    parameter int NUM_CORES     = DEF_NUM_CORES,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [7:0]             ui_in,
    output logic [7:0]             uo_out,
    input  logic [7:0]             uio_in,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe,
    output logic [NUM_CORES-1:0]   core_rst,
    output logic [7:0]             core_ui_in,
    output logic [7:0]             core_uio_in,
    input  logic [8*NUM_CORES-1:0] core_uo_out,
    input  logic [8*NUM_CORES-1:0] core_uio_out,
    input  logic [8*NUM_CORES-1:0] core_uio_oe,
    output logic                   sel_valid,
    output logic [SEL_W-1:0]       sel_idx
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic                 w_rst_sync_n;
    logic [7:0]           w_ui_sync;
    logic [7:0]           w_uio_sync;
    logic [SEL_W-1:0]     w_sel_next;
    logic                 w_sel_ok;
    logic [7:0]           w_uo;
    logic [7:0]           w_uio;
    logic [7:0]           w_oe;
    logic                 w_unused;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [SEL_W-1:0]     r_sel_idx;
    logic [NUM_CORES-1:0] r_core_rst;
    logic [7:0]           r_uo;
    logic [7:0]           r_uio;
    logic [7:0]           r_oe;
`ifdef TT_WRAP_SELFTEST_EN
    logic [7:0]           r_st_cnt;
`endif

    assign w_unused = &{1'b0, ena};

    tt_sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (1'b1),
        .o_q   (w_rst_sync_n)
    );

    tt_sync_chain #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_ui_sync (
        .clk   (clk),
        .rst_n (w_rst_sync_n),
        .i_d   (ui_in),
        .o_q   (w_ui_sync)
    );

    tt_sync_chain #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_uio_sync (
        .clk   (clk),
        .rst_n (w_rst_sync_n),
        .i_d   (uio_in),
        .o_q   (w_uio_sync)
    );

    assign w_sel_next = w_ui_sync[SEL_W-1:0];
    assign w_sel_ok   = (int'(w_sel_next) < NUM_CORES);

    // Explicit per-core compare keeps an out-of-range select from indexing past the bus.
    always_comb begin
        w_uo  = '0;
        w_uio = '0;
        w_oe  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (r_sel_idx == SEL_W'(k)) begin
                w_uo  = core_uo_out[slice_lo(k) +: 8];
                w_uio = core_uio_out[slice_lo(k) +: 8];
                w_oe  = core_uio_oe[slice_lo(k) +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_sel_idx  <= '0;
            r_core_rst <= '1;
            r_uo       <= '0;
            r_uio      <= '0;
            r_oe       <= '0;
`ifdef TT_WRAP_SELFTEST_EN
            r_st_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_SETTLE;
                    r_cnt   <= '0;
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_sel_idx <= w_sel_next;
                        if (w_sel_ok) begin
                            r_state <= ST_RUN;
`ifdef TT_WRAP_SELFTEST_EN
                        end else if (w_sel_next == '1) begin
                            r_state <= ST_SELFTEST;
`endif
                        end else begin
                            r_state <= ST_HALT;
                        end
                    end
                end
                default: ;
            endcase

            // Pads and core resets follow the state held before this edge.
            case (r_state)
                ST_RUN: begin
                    r_core_rst <= ~(NUM_CORES'(1) << r_sel_idx);
                    r_uo       <= w_uo;
                    r_uio      <= w_uio;
                    r_oe       <= w_oe;
                end
`ifdef TT_WRAP_SELFTEST_EN
                ST_SELFTEST: begin
                    r_core_rst <= '1;
                    r_uo       <= r_st_cnt;
                    r_uio      <= w_ui_sync;
                    r_oe       <= 8'hFF;
                    r_st_cnt   <= r_st_cnt + 8'd1;
                end
`endif
                default: begin
                    r_core_rst <= '1;
                    r_uo       <= '0;
                    r_uio      <= '0;
                    r_oe       <= '0;
                end
            endcase
        end
    end

    assign uo_out      = r_uo;
    assign uio_out     = r_uio;
    assign uio_oe      = r_oe;
    assign core_rst    = r_core_rst;
    assign core_ui_in  = w_ui_sync;
    assign core_uio_in = w_uio_sync;
    assign sel_valid   = (r_state == ST_RUN);
    assign sel_idx     = r_sel_idx;

endmodule

// File: tb/tb_tt_core_select_wrapper.sv
// Bench for tt_core_select_wrapper: edge-count model checked every cycle plus directed literals.
module tb_tt_core_select_wrapper;

    localparam int NC = 2;
    localparam int SW = 2;
    localparam int SS = 2;
    localparam int SC = 8;
    localparam int E  = SS + SC + 1;   // edge after release at which the select takes effect

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic [7:0]      ui_in;
    logic [7:0]      uo_out;
    logic [7:0]      uio_in;
    logic [7:0]      uio_out;
    logic [7:0]      uio_oe;
    logic [NC-1:0]   core_rst;
    logic [7:0]      core_ui_in;
    logic [7:0]      core_uio_in;
    logic [8*NC-1:0] core_uo_out;
    logic [8*NC-1:0] core_uio_out;
    logic [8*NC-1:0] core_uio_oe;
    logic            sel_valid;
    logic [SW-1:0]   sel_idx;

    tt_core_select_wrapper #(
        .NUM_CORES(NC), .SEL_W(SW), .SYNC_STAGES(SS), .SETTLE_CYCLES(SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .uio_in       (uio_in),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe),
        .core_rst     (core_rst),
        .core_ui_in   (core_ui_in),
        .core_uio_in  (core_uio_in),
        .core_uo_out  (core_uo_out),
        .core_uio_out (core_uio_out),
        .core_uio_oe  (core_uio_oe),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Input history, indexed by the clock edge (counted from reset release) that samples it.
    logic [7:0]      ui_h   [0:1023];
    logic [7:0]      uio_h  [0:1023];
    logic [8*NC-1:0] cuo_h  [0:1023];
    logic [8*NC-1:0] cuio_h [0:1023];
    logic [8*NC-1:0] coe_h  [0:1023];

    // Synchronised value visible after edge m: inputs only enter once the reset sync is high.
    function automatic logic [7:0] sync_ui(input int m);
        int src;
        src = m - SS + 1;
        return (src >= SS + 1) ? ui_h[src] : 8'h00;
    endfunction

    function automatic logic [7:0] sync_uio(input int m);
        int src;
        src = m - SS + 1;
        return (src >= SS + 1) ? uio_h[src] : 8'h00;
    endfunction

    function automatic int sel_model();
        return int'(sync_ui(E - 1)) % (1 << SW);
    endfunction

    // 0 reset, 1 settle, 2 run, 3 halt, 4 selftest
    function automatic int st_of(input int m);
        int s;
        if (m <= SS) return 0;
        if (m < E) return 1;
        s = sel_model();
        if (s < NC) return 2;
`ifdef TT_WRAP_SELFTEST_EN
        if (s == (1 << SW) - 1) return 4;
`endif
        return 3;
    endfunction

    initial begin : compare
        int n;
        int sp;
        int s;
        logic prev;
        logic [8*NC-1:0] t_uo, t_uio, t_oe;
        logic [7:0] e_uo, e_uio, e_oe, e_ui, e_uiob;
        logic [NC-1:0] e_rst;
        logic e_sv;
        logic [SW-1:0] e_sel;
        n = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) n = 0;
            else if (prev) n++;
            else n = 0;
            prev = rst_n;
            if (n > 1000) n = 1000;
            ui_h[n+1]   = ui_in;
            uio_h[n+1]  = uio_in;
            cuo_h[n+1]  = core_uo_out;
            cuio_h[n+1] = core_uio_out;
            coe_h[n+1]  = core_uio_oe;
            if (n == 0) begin
                e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00; e_rst = '1;
                e_sv = 1'b0; e_sel = '0; e_ui = 8'h00; e_uiob = 8'h00;
            end else begin
                s  = (n >= E) ? sel_model() : 0;
                sp = st_of(n - 1);
                t_uo = cuo_h[n]; t_uio = cuio_h[n]; t_oe = coe_h[n];
                e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00; e_rst = '1;
                if (sp == 2) begin
                    e_uo  = t_uo[8*s +: 8];
                    e_uio = t_uio[8*s +: 8];
                    e_oe  = t_oe[8*s +: 8];
                    e_rst = ~(NC'(1) << s);
                end else if (sp == 4) begin
                    e_uo  = 8'(n - E - 1);
                    e_uio = sync_ui(n - 1);
                    e_oe  = 8'hFF;
                end
                e_sv   = (st_of(n) == 2);
                e_sel  = (n >= E) ? SW'(s) : '0;
                e_ui   = sync_ui(n);
                e_uiob = sync_uio(n);
            end
            chk("model_uo_out", uo_out, e_uo);
            chk("model_uio_out", uio_out, e_uio);
            chk("model_uio_oe", uio_oe, e_oe);
            chk("model_core_rst", core_rst, e_rst);
            chk("model_sel_valid", sel_valid, e_sv);
            chk("model_sel_idx", sel_idx, e_sel);
            chk("model_core_ui_in", core_ui_in, e_ui);
            chk("model_core_uio_in", core_uio_in, e_uiob);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counts edges after release until sel_valid; leaves time at posedge+1.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk);
            cyc++;
            #1;
            if (sel_valid) break;
        end
        if (!sel_valid) begin
            errors++;
            checks++;
            $display("FAIL wait_sel_valid: got timeout after %0d cycles expected rise", cyc);
        end
    endtask

    initial begin : stim
        int cyc;
        rst_n        = 1'b0;
        ena          = 1'b1;
        ui_in        = 8'h01;
        uio_in       = 8'h5C;
        core_uo_out  = {8'h22, 8'h11};
        core_uio_out = {8'h44, 8'h33};
        core_uio_oe  = {8'h66, 8'h55};
        repeat (3) tick();
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_core_rst", core_rst, 2'b11);
        chk("reset_sel_valid", sel_valid, 1'b0);

        // core 1 selected
        rst_n = 1'b1;
        wait_valid(cyc);
        chk("sel_valid_latency", cyc, 11);
        chk("core_rst_at_run_entry", core_rst, 2'b11);
        chk("sel_idx_core1", sel_idx, 2'd1);
        tick();
        chk("core_rst_core1", core_rst, 2'b01);
        chk("uo_core1", uo_out, 8'h22);
        chk("uio_oe_core1", uio_oe, 8'h66);
        core_uo_out[15:8] = 8'h5A;
        @(posedge clk); #1;
        chk("uo_core1_follow", uo_out, 8'h5A);
        #1;
        ui_in = 8'h00;
        @(posedge clk); #1;
        chk("ui_sync_1cyc", core_ui_in, 8'h01);
        @(posedge clk); #1;
        chk("ui_sync_2cyc", core_ui_in, 8'h00);
        #1;
        repeat (4) tick();
        chk("sel_idx_held", sel_idx, 2'd1);
        chk("sel_valid_held", sel_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            core_uo_out  = {8'(i * 17), 8'(~i)};
            core_uio_out = {8'(i + 8'h40), 8'(i + 8'h80)};
            core_uio_oe  = {8'(i << 4), 8'(i)};
            uio_in       = 8'(i * 3);
            tick();
        end

        // async reset mid-run, then core 0 selected
        rst_n = 1'b0;
        #1;
        chk("midrun_uo_cleared", uo_out, 8'h00);
        chk("midrun_oe_cleared", uio_oe, 8'h00);
        chk("midrun_core_rst", core_rst, 2'b11);
        chk("midrun_sel_valid", sel_valid, 1'b0);
        core_uo_out  = {8'h77, 8'hA5};
        core_uio_out = {8'h88, 8'h3C};
        core_uio_oe  = {8'h99, 8'h0F};
        repeat (2) tick();
        rst_n = 1'b1;
        wait_valid(cyc);
        chk("sel_valid_latency2", cyc, 11);
        chk("sel_idx_core0", sel_idx, 2'd0);
        tick();
        chk("core_rst_core0", core_rst, 2'b10);
        chk("uo_core0", uo_out, 8'hA5);
        chk("uio_core0", uio_out, 8'h3C);
        chk("oe_core0", uio_oe, 8'h0F);
        core_uo_out[7:0] = 8'h96;
        @(posedge clk); #1;
        chk("uo_core0_follow", uo_out, 8'h96);
        #1;

        // invalid select -> halt
        rst_n = 1'b0;
        ui_in = 8'h02;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("halt_sel_valid", sel_valid, 1'b0);
        chk("halt_core_rst", core_rst, 2'b11);
        chk("halt_uo", uo_out, 8'h00);
        chk("halt_oe", uio_oe, 8'h00);
        chk("halt_sel_idx", sel_idx, 2'd2);

`ifdef TT_WRAP_SELFTEST_EN
        rst_n = 1'b0;
        ui_in = 8'h03;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (E + 1) @(posedge clk);
        #1;
        chk("selftest_uo0", uo_out, 8'h00);
        chk("selftest_oe", uio_oe, 8'hFF);
        @(posedge clk); #1;
        chk("selftest_uo1", uo_out, 8'h01);
        @(posedge clk); #1;
        chk("selftest_uo2", uo_out, 8'h02);
        chk("selftest_uio", uio_out, 8'h03);
        chk("selftest_core_rst", core_rst, 2'b11);
        chk("selftest_sel_valid", sel_valid, 1'b0);
        #1;
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
